// File: rtl/nv_nvdla_rubik_rf_wseq.sv
// nv_nvdla_rubik_rf_wseq
//   Rubik read-fetch write sequencer. Takes write commands from the wcmd FIFO,
//   pairs every command with len+1 beats of fetched data and writes each beat
//   into the reshape buffer at (start + beat index) mod 32. A credit counter
//   tracks free reshape-buffer entries so the sequencer never overruns the
//   reader.
//
// Ports
//   nvdla_core_clk / nvdla_core_rst : clock, async active-high reset
//   wcmd_pvld/prdy/pd               : command in {last, start[4:0], len[4:0]}
//   dp_pvld/prdy/pd                 : data beat in
//   rf_wr_en/addr/data              : registered reshape-buffer write port
//   rf_release                      : reader freed one entry (1-cycle pulse)
//   surf_done                       : final write of a last-flagged command
//   busy                            : burst in progress or write in flight
//   cred_err                        : sticky, release seen with credits full
module nv_nvdla_rubik_rf_wseq #(
  parameter int DW    = 64,
  parameter int DEPTH = 32
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          wcmd_pvld,
  output logic          wcmd_prdy,
  input  logic [10:0]   wcmd_pd,
  input  logic          dp_pvld,
  output logic          dp_prdy,
  input  logic [DW-1:0] dp_pd,
  output logic          rf_wr_en,
  output logic [4:0]    rf_wr_addr,
  output logic [DW-1:0] rf_wr_data,
  input  logic          rf_release,
  output logic          surf_done,
  output logic          busy,
  output logic          cred_err
);

  localparam int AW = 5;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e          state_q;
  logic [AW-1:0]   start_q, len_q, beat_cnt_q;
  logic            last_q;
  logic [CW-1:0]   credit_q, credit_d;
  logic            err_q, err_d;
  logic            wr_en_q, surf_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;

  logic            cmd_acc, beat_acc, final_beat;

  assign wcmd_prdy  = (state_q == IDLE);
  assign dp_prdy    = (state_q == BURST) && (credit_q != '0);
  assign cmd_acc    = wcmd_pvld && wcmd_prdy;
  assign beat_acc   = dp_pvld && dp_prdy;
  assign final_beat = beat_acc && (beat_cnt_q == len_q);

  // Beat and release in the same cycle cancel. A release with every entry
  // already free is a reader bug: hold at full and flag it.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    unique case ({beat_acc, rf_release})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CRED_MAX) err_d = 1'b1;
        else                      credit_d = credit_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q    <= IDLE;
      start_q    <= '0;
      len_q      <= '0;
      last_q     <= 1'b0;
      beat_cnt_q <= '0;
      credit_q   <= CRED_MAX;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      surf_q     <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
      wr_en_q  <= beat_acc;
      surf_q   <= final_beat && last_q;
      if (beat_acc) begin
        wr_addr_q <= start_q + beat_cnt_q;  // 5-bit add wraps the ring
        wr_data_q <= dp_pd;
      end
      unique case (state_q)
        IDLE: if (cmd_acc) begin
          len_q      <= wcmd_pd[4:0];
          start_q    <= wcmd_pd[9:5];
          last_q     <= wcmd_pd[10];
          beat_cnt_q <= '0;
          state_q    <= BURST;
        end
        BURST: if (beat_acc) begin
          // Skip the increment on the final beat so len=31 never wraps.
          if (final_beat) state_q    <= IDLE;
          else            beat_cnt_q <= beat_cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;
  assign surf_done  = surf_q;
  assign cred_err   = err_q;
  assign busy       = (state_q == BURST) || wr_en_q;

endmodule

// File: tb/tb_nv_nvdla_rubik_rf_wseq.sv
module tb_nv_nvdla_rubik_rf_wseq;
  localparam int DW = 64;

  logic          clk = 1'b0, rst = 1'b1;
  logic          wcmd_pvld = 1'b0, wcmd_prdy;
  logic [10:0]   wcmd_pd = '0;
  logic          dp_pvld = 1'b0, dp_prdy;
  logic [DW-1:0] dp_pd = '0;
  logic          rf_wr_en;
  logic [4:0]    rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic          rf_release = 1'b0;
  logic          surf_done, busy, cred_err;

  always #5 clk = ~clk;

  nv_nvdla_rubik_rf_wseq #(.DW(DW), .DEPTH(32)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .wcmd_pvld(wcmd_pvld), .wcmd_prdy(wcmd_prdy), .wcmd_pd(wcmd_pd),
    .dp_pvld(dp_pvld), .dp_prdy(dp_prdy), .dp_pd(dp_pd),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_release(rf_release), .surf_done(surf_done), .busy(busy),
    .cred_err(cred_err)
  );

  int n_chk = 0, n_err = 0, cyc = 0, hs_cyc = 0;
  bit chk_en = 0;

  // Reference model: the command in flight, beats delivered so far, free
  // entries, and the write that must be visible after the next edge.
  bit            m_burst, m_last, m_err;
  int            m_start, m_len, m_count, m_credit;
  bit            exp_wr, exp_surf;
  int            exp_addr;
  logic [DW-1:0] exp_data;

  logic [10:0] cmd_q[$];
  int dp_mode = 0, rl_mode = 0, rl_target = 0;

  int log_addr[$], log_cyc[$];
  bit log_surf[$], log_prdy[$];

  int e1[4] = '{3, 4, 5, 6};
  int e2[5] = '{30, 31, 0, 1, 2};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_burst = 0; m_last = 0; m_err = 0;
    m_start = 0; m_len = 0; m_count = 0; m_credit = 32;
    exp_wr = 0; exp_surf = 0; exp_addr = 0; exp_data = '0;
  endtask

  task automatic model_step();
    bit acc, hs;
    acc = m_burst && (m_credit > 0) && dp_pvld;
    hs  = !m_burst && wcmd_pvld;
    exp_wr   = acc;
    exp_surf = acc && m_last && (m_count == m_len);
    if (acc) begin
      exp_addr = (m_start + m_count) % 32;
      exp_data = dp_pd;
    end
    if (acc && !rf_release) m_credit--;
    else if (rf_release && !acc) begin
      if (m_credit == 32) m_err = 1;
      else m_credit++;
    end
    if (acc) begin
      m_count++;
      if (m_count > m_len) m_burst = 0;
    end
    if (hs) begin
      m_len = int'(wcmd_pd[4:0]); m_start = int'(wcmd_pd[9:5]);
      m_last = wcmd_pd[10]; m_count = 0; m_burst = 1;
      void'(cmd_q.pop_front());
    end
  endtask

  // One clock: advance the model on the edge, then drive the next inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    wcmd_pvld = !rst && (cmd_q.size() > 0);
    wcmd_pd   = (cmd_q.size() > 0) ? cmd_q[0] : 11'd0;
    dp_pd     = {$urandom, $urandom};
    case (dp_mode)
      0:       dp_pvld = 1'b0;
      1:       dp_pvld = 1'b1;
      default: dp_pvld = 1'($urandom_range(0, 1));
    endcase
    case (rl_mode)
      0: rf_release = 1'b0;
      1: rf_release = 1'b1;
      2: rf_release = ($urandom_range(0, 3) == 0);
      3: begin rf_release = 1'b1; rl_mode = 0; end
      4: rf_release = (m_credit < rl_target);
      default: rf_release = m_burst;
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((m_burst || cmd_q.size() > 0) && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      n_chk++; n_err++;
      $display("FAIL idle_timeout: still busy after %0d cycles", budget);
    end
  endtask

  task automatic set_credit(input int t);
    int n = 0;
    dp_mode = 0; rl_target = t; rl_mode = 4;
    while (m_credit < t && n < 100) begin tick(); n++; end
    rl_mode = 0; tick();
    chk("set_credit", 64'(m_credit), 64'(t));
  endtask

  task automatic clear_log();
    log_addr.delete(); log_cyc.delete(); log_surf.delete(); log_prdy.delete();
  endtask

  // Compare process: every cycle, all outputs against the model.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst && chk_en) begin
      chk("wcmd_prdy", 64'(wcmd_prdy), 64'(!m_burst));
      chk("dp_prdy", 64'(dp_prdy), 64'(m_burst && m_credit > 0));
      chk("rf_wr_en", 64'(rf_wr_en), 64'(exp_wr));
      if (exp_wr) begin
        chk("rf_wr_addr", 64'(rf_wr_addr), 64'(exp_addr));
        chk("rf_wr_data", rf_wr_data, exp_data);
      end
      chk("surf_done", 64'(surf_done), 64'(exp_surf));
      chk("busy", 64'(busy), 64'(m_burst || exp_wr));
      chk("cred_err", 64'(cred_err), 64'(m_err));
      chk("credit", 64'(dut.credit_q), 64'(m_credit));
      if (rf_wr_en) begin
        log_addr.push_back(int'(rf_wr_addr)); log_cyc.push_back(cyc);
        log_surf.push_back(surf_done); log_prdy.push_back(wcmd_prdy);
      end
      if (wcmd_pvld && !m_burst) hs_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nsurf, n;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;
    // Reset values
    chk("rst_wcmd_prdy", 64'(wcmd_prdy), 64'd1);
    chk("rst_dp_prdy", 64'(dp_prdy), 64'd0);
    chk("rst_wr_en", 64'(rf_wr_en), 64'd0);
    chk("rst_wr_addr", 64'(rf_wr_addr), 64'd0);
    chk("rst_wr_data", rf_wr_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cred_err", 64'(cred_err), 64'd0);
    chk("rst_credit", 64'(dut.credit_q), 64'd32);

    // T1: last=1 start=3 len=3
    clear_log(); dp_mode = 1;
    cmd_q.push_back({1'b1, 5'd3, 5'd3});
    run_idle(100); run(3);
    chk("t1_nwr", 64'(log_addr.size()), 64'd4);
    if (log_addr.size() == 4) begin
      foreach (e1[i]) chk("t1_addr", 64'(log_addr[i]), 64'(e1[i]));
      chk("t1_latency", 64'(log_cyc[0] - hs_cyc), 64'd2);
      chk("t1_back2back", 64'(log_cyc[3] - log_cyc[0]), 64'd3);
      chk("t1_surf_last", 64'(log_surf[3]), 64'd1);
      chk("t1_prdy_back", 64'(log_prdy[3]), 64'd1);
    end
    nsurf = 0; foreach (log_surf[i]) nsurf += int'(log_surf[i]);
    chk("t1_nsurf", 64'(nsurf), 64'd1);

    // T2: wrap, no surf
    clear_log();
    cmd_q.push_back({1'b0, 5'd30, 5'd4});
    run_idle(100); run(3);
    chk("t2_nwr", 64'(log_addr.size()), 64'd5);
    if (log_addr.size() == 5)
      foreach (e2[i]) chk("t2_addr", 64'(log_addr[i]), 64'(e2[i]));
    nsurf = 0; foreach (log_surf[i]) nsurf += int'(log_surf[i]);
    chk("t2_nsurf", 64'(nsurf), 64'd0);

    // T3: credit exhaustion, then release-paced beats
    set_credit(32);
    clear_log(); dp_mode = 1;
    repeat (3) cmd_q.push_back({1'b0, 5'($urandom), 5'd31});
    run(80);
    chk("t3_nwr_stall", 64'(log_addr.size()), 64'd32);
    chk("t3_dp_prdy", 64'(dp_prdy), 64'd0);
    chk("t3_credit0", 64'(dut.credit_q), 64'd0);
    repeat (5) begin rl_mode = 3; run(4); end
    chk("t3_nwr_rel", 64'(log_addr.size()), 64'd37);
    rl_mode = 2; run_idle(2000); rl_mode = 0; run(2);

    // T4: release and beat every cycle at credit 10
    set_credit(10);
    clear_log(); dp_mode = 1; rl_mode = 5;
    cmd_q.push_back({1'b0, 5'($urandom), 5'd31});
    run_idle(100); rl_mode = 0; run(2);
    chk("t4_credit", 64'(dut.credit_q), 64'd10);
    chk("t4_nwr", 64'(log_addr.size()), 64'd32);
    if (log_addr.size() == 32) chk("t4_nostall", 64'(log_cyc[31] - log_cyc[0]), 64'd31);

    // T5: release with credits full
    set_credit(32);
    chk("t5_err_before", 64'(cred_err), 64'd0);
    rl_mode = 3; run(2);
    chk("t5_err_set", 64'(cred_err), 64'd1);
    chk("t5_credit", 64'(dut.credit_q), 64'd32);
    run(5);
    chk("t5_err_sticky", 64'(cred_err), 64'd1);

    // Randomized traffic
    dp_mode = 2; rl_mode = 2;
    repeat (60) cmd_q.push_back({1'($urandom), 5'($urandom), 5'($urandom)});
    run_idle(20000);
    rl_mode = 0; dp_mode = 0; run(2);

    // Asynchronous reset mid-burst (after beat 2 of len=7)
    set_credit(32);
    dp_mode = 1;
    cmd_q.push_back({1'b1, 5'($urandom), 5'd7});
    n = 0;
    while (!(m_burst && m_count == 2) && n < 50) begin tick(); n++; end
    chk("rst_mid_reached", 64'(m_count), 64'd2);
    #1 rst = 1'b1;
    cmd_q.delete(); model_reset(); dp_mode = 0;
    #1;
    chk("arst_wr_en", 64'(rf_wr_en), 64'd0);
    chk("arst_wcmd_prdy", 64'(wcmd_prdy), 64'd1);
    chk("arst_dp_prdy", 64'(dp_prdy), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_surf", 64'(surf_done), 64'd0);
    chk("arst_cred_err", 64'(cred_err), 64'd0);
    chk("arst_wr_addr", 64'(rf_wr_addr), 64'd0);
    chk("arst_wr_data", rf_wr_data, 64'd0);
    chk("arst_credit", 64'(dut.credit_q), 64'd32);
    run(2);
    rst = 1'b0;
    clear_log(); dp_mode = 1;
    cmd_q.push_back({1'b0, 5'd0, 5'd0});
    run_idle(20); run(3);
    chk("post_nwr", 64'(log_addr.size()), 64'd1);
    if (log_addr.size() == 1) chk("post_addr", 64'(log_addr[0]), 64'd0);
    chk("post_credit", 64'(dut.credit_q), 64'd31);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
